// File: rtl/mem_copy_master.sv
// Memory-to-memory copy initiator: streams beat-aligned reads from a source region
// and writes the returned beats to a destination region, masking the final partial beat.
module mem_copy_master #(
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 64,
    parameter int MASK_WIDTH      = DATA_WIDTH / 8,
    parameter int ADDR_ALIGN_BITS = $clog2(MASK_WIDTH),
    parameter int LEN_WIDTH       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_src_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_dst_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_rd_data_vld,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [MASK_WIDTH-1:0] mem_wr_datastrb,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr
);

    localparam int CNT_W = LEN_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(MASK_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        FIN,
        ERR
    } state_t;

    state_t state_reg, state_next;

    logic [CNT_W-1:0]      n_beats_reg;
    logic [CNT_W-1:0]      rd_cnt_reg;
    logic [CNT_W-1:0]      wr_cnt_reg;
    logic [ADDR_WIDTH-1:0] rd_addr_reg;
    logic [ADDR_WIDTH-1:0] wr_beat_addr_reg;
    logic [MASK_WIDTH-1:0] last_strb_reg;
    logic                  rd_pending_reg;
    logic [DATA_WIDTH-1:0] wr_data_reg;
    logic [ADDR_WIDTH-1:0] wr_addr_reg;
    logic [MASK_WIDTH-1:0] wr_strb_reg;
    logic                  wr_last_reg;

    logic                       accept;
    logic                       misaligned;
    logic [CNT_W-1:0]           n_beats_cmd;
    logic [ADDR_ALIGN_BITS-1:0] len_rem;
    logic [MASK_WIDTH-1:0]      last_strb_cmd;
    logic                       wr_take;
    logic                       wr_is_last;

    assign accept      = cmd_valid && (state_reg == IDLE);
    assign misaligned  = (|cmd_src_addr[ADDR_ALIGN_BITS-1:0]) || (|cmd_dst_addr[ADDR_ALIGN_BITS-1:0]);
    // Widened by one bit so a maximum-length command cannot overflow the round-up.
    assign n_beats_cmd = ({1'b0, cmd_len} + CNT_W'(MASK_WIDTH - 1)) >> ADDR_ALIGN_BITS;
    assign len_rem     = cmd_len[ADDR_ALIGN_BITS-1:0];

    generate
        for (genvar gi = 0; gi < MASK_WIDTH; gi++) begin : g_last_strb
            assign last_strb_cmd[gi] = (len_rem == '0) || (ADDR_ALIGN_BITS'(gi) < len_rem);
        end
    endgenerate

    // Writes follow returned data, so a stray valid with no read in flight is dropped.
    assign wr_take    = mem_rd_data_vld && rd_pending_reg;
    assign wr_is_last = (wr_cnt_reg == n_beats_reg - CNT_W'(1));

    always_comb begin
        state_next  = state_reg;
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        err         = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (accept) begin
                    if (misaligned)
                        state_next = ERR;
                    else if (cmd_len == '0)
                        state_next = FIN;
                    else
                        state_next = READ;
                end
            end
            READ: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = rd_addr_reg;
                if (rd_cnt_reg == n_beats_reg - CNT_W'(1))
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (wr_last_reg)
                    state_next = FIN;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                done       = 1'b1;
                err        = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            n_beats_reg      <= '0;
            rd_cnt_reg       <= '0;
            wr_cnt_reg       <= '0;
            rd_addr_reg      <= '0;
            wr_beat_addr_reg <= '0;
            last_strb_reg    <= '0;
            rd_pending_reg   <= 1'b0;
            wr_data_reg      <= '0;
            wr_addr_reg      <= '0;
            wr_strb_reg      <= '0;
            wr_last_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rd_pending_reg <= (state_reg == READ);

            if (accept) begin
                n_beats_reg      <= n_beats_cmd;
                last_strb_reg    <= last_strb_cmd;
                rd_addr_reg      <= cmd_src_addr;
                wr_beat_addr_reg <= cmd_dst_addr;
                rd_cnt_reg       <= '0;
                wr_cnt_reg       <= '0;
            end

            if (state_reg == READ) begin
                rd_addr_reg <= rd_addr_reg + BEAT_BYTES;
                rd_cnt_reg  <= rd_cnt_reg + CNT_W'(1);
            end

            wr_strb_reg <= '0;
            wr_last_reg <= 1'b0;
            if (wr_take) begin
                wr_data_reg      <= mem_rd_data;
                wr_addr_reg      <= wr_beat_addr_reg;
                wr_strb_reg      <= wr_is_last ? last_strb_reg : '1;
                wr_last_reg      <= wr_is_last;
                wr_beat_addr_reg <= wr_beat_addr_reg + BEAT_BYTES;
                wr_cnt_reg       <= wr_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign mem_wr_data     = wr_data_reg;
    assign mem_wr_addr     = wr_addr_reg;
    assign mem_wr_datastrb = wr_strb_reg;

endmodule

// File: tb/tb_mem_copy_master.sv
// Randomized bench for mem_copy_master: a byte-array host memory responds to the DUT,
// and a copy-level reference predicts traffic timing, strobes and final memory contents.
module tb_mem_copy_master;

    localparam int DW = 512;
    localparam int AW = 64;
    localparam int MW = 64;
    localparam int LW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_src_addr = '0;
    logic [AW-1:0] cmd_dst_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          busy, done, err;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          mem_rd_data_vld = 1'b0;
    logic [DW-1:0] mem_wr_data;
    logic [MW-1:0] mem_wr_datastrb;
    logic [AW-1:0] mem_wr_addr;

    always #5 clk = ~clk;

    mem_copy_master dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_src_addr    (cmd_src_addr),
        .cmd_dst_addr    (cmd_dst_addr),
        .cmd_len         (cmd_len),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .mem_rd_en       (mem_rd_en),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_data     (mem_rd_data),
        .mem_rd_data_vld (mem_rd_data_vld),
        .mem_wr_data     (mem_wr_data),
        .mem_wr_datastrb (mem_wr_datastrb),
        .mem_wr_addr     (mem_wr_addr)
    );

    typedef struct {
        int          c;
        logic [63:0] addr;
        logic [63:0] strb;
        logic        e;
    } ev_t;

    bit [7:0] mem     [0:65535];
    bit [7:0] ref_mem [0:65535];
    ev_t rd_q[$];
    ev_t wr_q[$];
    ev_t dn_q[$];
    int  rd_i = 0, wr_i = 0, dn_i = 0;
    int  tests = 0, fails = 0;
    int  cyc = 0;
    bit  inject = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Host memory: records traffic and applies writes at the falling edge.
    always @(negedge clk) begin
        if (mem_rd_en) rd_q.push_back('{c: cyc, addr: mem_rd_addr, strb: 64'd0, e: 1'b0});
        if (mem_wr_datastrb != '0) begin
            wr_q.push_back('{c: cyc, addr: mem_wr_addr, strb: mem_wr_datastrb, e: 1'b0});
            for (int b = 0; b < MW; b++)
                if (mem_wr_datastrb[b]) mem[16'(mem_wr_addr + 64'(b))] = mem_wr_data[8*b +: 8];
        end
        if (done) dn_q.push_back('{c: cyc, addr: 64'd0, strb: 64'd0, e: err});
    end

    // Read responder: data for a read seen in cycle t is presented throughout cycle t+1.
    initial begin
        logic          p;
        logic          inj;
        logic [AW-1:0] a;
        forever begin
            @(negedge clk);
            p   = mem_rd_en;
            a   = mem_rd_addr;
            inj = inject;
            @(posedge clk);
            #1;
            mem_rd_data_vld = p | inj;
            for (int b = 0; b < MW; b++) mem_rd_data[8*b +: 8] = mem[16'(a + 64'(b))];
        end
    end

    task automatic issue(input logic [63:0] s, input logic [63:0] d, input int l, output int acc);
        @(negedge clk);
        cmd_valid    = 1'b1;
        cmd_src_addr = s;
        cmd_dst_addr = d;
        cmd_len      = LW'(l);
        acc = -1;
        for (int t = 0; t < 300; t++) begin
            if (cmd_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) check("accept_timeout", 64'd0, 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int t = 0; t < 3000 && dn_q.size() < target; t++) @(negedge clk);
        if (dn_q.size() < target) check("done_timeout", 64'(dn_q.size()), 64'(target));
    endtask

    // Predicts the traffic for one command from its fields and accept cycle, then checks memory.
    task automatic check_cmd(input logic [63:0] s, input logic [63:0] d, input int l, input int acc);
        bit          mis;
        int          n, r, lat, bad;
        logic [63:0] es;
        mis = (s[5:0] != 6'd0) || (d[5:0] != 6'd0);
        n   = mis ? 0 : (l + MW - 1) / MW;
        r   = l % MW;
        for (int k = 0; k < n; k++) begin
            if (rd_i >= rd_q.size()) begin
                check("rd_missing", 64'(rd_q.size()), 64'(rd_i + 1));
                break;
            end
            check("rd_cycle", 64'(rd_q[rd_i].c), 64'(acc + 1 + k));
            check("rd_addr", rd_q[rd_i].addr, s + 64'(k) * 64'(MW));
            rd_i++;
        end
        for (int k = 0; k < n; k++) begin
            if (wr_i >= wr_q.size()) begin
                check("wr_missing", 64'(wr_q.size()), 64'(wr_i + 1));
                break;
            end
            es = (k == n - 1 && r != 0) ? ((64'd1 << r) - 64'd1) : {64{1'b1}};
            check("wr_cycle", 64'(wr_q[wr_i].c), 64'(acc + 3 + k));
            check("wr_addr", wr_q[wr_i].addr, d + 64'(k) * 64'(MW));
            check("wr_strb", wr_q[wr_i].strb, es);
            wr_i++;
        end
        lat = (mis || l == 0) ? 1 : n + 3;
        if (dn_i >= dn_q.size()) begin
            check("done_missing", 64'(dn_q.size()), 64'(dn_i + 1));
        end else begin
            check("done_cycle", 64'(dn_q[dn_i].c), 64'(acc + lat));
            check("err", 64'(dn_q[dn_i].e), 64'(mis));
            dn_i++;
        end
        if (!mis)
            for (int i = 0; i < l; i++) ref_mem[16'(d + 64'(i))] = ref_mem[16'(s + 64'(i))];
        bad = 0;
        for (int i = 0; i < (n + 1) * MW; i++)
            if (mem[16'(d + 64'(i))] != ref_mem[16'(d + 64'(i))]) bad++;
        check("dst_bytes", 64'(bad), 64'd0);
    endtask

    task automatic run(input logic [63:0] s, input logic [63:0] d, input int l);
        int acc;
        issue(s, d, l, acc);
        wait_done(dn_i + 1);
        repeat (2) @(negedge clk);
        check_cmd(s, d, l, acc);
    endtask

    initial begin
        int acc, acc2;
        logic [63:0] s, d;
        int l;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        ref_mem = mem;

        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({cmd_ready, busy, done, err, mem_rd_en}), 64'b10000);
        check("reset_strb", mem_wr_datastrb, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run(64'h1000, 64'h8000, 256);
        run(64'h1100, 64'h8200, 100);
        run(64'h1200, 64'h8400, 0);

        // Misaligned source: error pulse with done, then ready again.
        issue(64'h1004, 64'h8600, 128, acc);
        check("err_done_now", 64'({done, err}), 64'b11);
        @(negedge clk);
        check("err_ready_after", 64'(cmd_ready), 64'd1);
        repeat (2) @(negedge clk);
        check_cmd(64'h1004, 64'h8600, 128, acc);

        // Stray read-valid while idle must not produce a write.
        @(posedge clk); #2 inject = 1'b1;
        @(posedge clk); #2 inject = 1'b0;
        repeat (4) @(negedge clk);
        check("stray_vld_no_wr", 64'(wr_q.size()), 64'(wr_i));

        // cmd_valid held high across a 4-beat copy; second command queued behind it.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_src_addr = 64'h2000; cmd_dst_addr = 64'h9000; cmd_len = 32'd256;
        acc = -1;
        for (int t = 0; t < 100; t++) begin
            if (cmd_ready) begin acc = cyc; break; end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_src_addr = 64'h2400; cmd_dst_addr = 64'h9800; cmd_len = 32'd130;
        acc2 = -1;
        for (int t = 0; t < 100; t++) begin
            if (cmd_ready) begin acc2 = cyc; break; end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(dn_i + 2);
        repeat (2) @(negedge clk);
        check("b2b_accept", 64'(acc2), 64'(acc + (256 + MW - 1) / MW + 4));
        check_cmd(64'h2000, 64'h9000, 256, acc);
        check_cmd(64'h2400, 64'h9800, 130, acc2);

        // Reset during the second read beat of an 8-beat copy.
        issue(64'h3000, 64'hA000, 512, acc);
        @(negedge clk);
        check("rst_pre_rd_addr", mem_rd_addr, 64'h3040);
        rst = 1'b1;
        #1;
        check("rst_mid_ctrl", 64'({cmd_ready, busy, done, err, mem_rd_en}), 64'b10000);
        check("rst_mid_strb", mem_wr_datastrb, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("rst_no_wr", 64'(wr_q.size()), 64'(wr_i));
        check("rst_no_done", 64'(dn_q.size()), 64'(dn_i));
        rd_i = rd_q.size();
        run(64'h3400, 64'hA800, 64);

        for (int n = 0; n < 10; n++) begin
            s = 64'($urandom_range(0, 255)) << 6;
            d = 64'h8000 + (64'($urandom_range(0, 255)) << 6);
            l = $urandom_range(0, 600);
            if ($urandom_range(0, 4) == 0) s = s | 64'($urandom_range(1, 63));
            else if ($urandom_range(0, 4) == 0) d = d | 64'($urandom_range(1, 63));
            run(s, d, l);
        end

        check("extra_rd", 64'(rd_q.size()), 64'(rd_i));
        check("extra_wr", 64'(wr_q.size()), 64'(wr_i));
        check("extra_done", 64'(dn_q.size()), 64'(dn_i));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
